// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port round-robin arbiter in front of a single fixed-latency memory.
// Only one transaction is in flight at a time. Each transaction runs
// IDLE -> ISSUE -> WAIT -> RESP.
//
// Parameters
//   MEM_LAT : cycles from the memory strobe until mem_out/mem_error are valid (1..15)
//
// Ports
//   clk, rst                  : clock and synchronous active-low reset
//   m0_* / m1_*               : requester ports (port 0 = CPU, port 1 = loader/DMA)
//      req, we, addr, wdata, size  : command inputs, held stable until gnt
//      gnt                         : one-cycle pulse, command captured
//      done                        : one-cycle pulse, response valid
//      rdata, err                  : response, held until that port's next done
//   mem_rd, mem_we            : memory strobes, high only in ISSUE
//   mem_addr, mem_data, mem_size : captured command, held until the next capture
//   mem_out, mem_error        : memory response
module mem_arbiter #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m1_req,
   input  logic        m0_we,
   input  logic        m1_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m0_wdata,
   input  logic [31:0] m1_wdata,
   input  logic [1:0]  m0_size,
   input  logic [1:0]  m1_size,
   output logic        m0_gnt,
   output logic        m1_gnt,
   output logic        m0_done,
   output logic        m1_done,
   output logic [31:0] m0_rdata,
   output logic [31:0] m1_rdata,
   output logic        m0_err,
   output logic        m1_err,
   output logic        mem_rd,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data,
   output logic [1:0]  mem_size,
   input  logic [31:0] mem_out,
   input  logic        mem_error
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t      state;
   state_t      state_next;
   logic        owner;
   logic        last_owner;
   logic        we_q;
   logic [3:0]  count;
   logic        capture;
   logic        pick;
   logic        sample;

   // State register. A reset in any state abandons the current transaction,
   // so no done is ever issued for it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and output decode. The pulses and strobes are pure decodes of
   // the state and the captured owner, so they drop as soon as a reset edge
   // returns the FSM to IDLE. On a tie the port that did not win last time
   // gets the grant.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      pick       = 1'b0;
      sample     = 1'b0;
      m0_gnt     = 1'b0;
      m1_gnt     = 1'b0;
      m0_done    = 1'b0;
      m1_done    = 1'b0;
      mem_rd     = 1'b0;
      mem_we     = 1'b0;
      case (state)
         IDLE: begin
            if (m0_req || m1_req) begin
               capture    = 1'b1;
               state_next = ISSUE;
               if (m0_req && m1_req) begin
                  pick = ~last_owner;
               end else begin
                  pick = m1_req;
               end
            end
         end
         ISSUE: begin
            m0_gnt     = ~owner;
            m1_gnt     = owner;
            mem_rd     = ~we_q;
            mem_we     = we_q;
            state_next = WAIT;
         end
         WAIT: begin
            if (count == 4'd1) begin
               sample     = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            m0_done    = ~owner;
            m1_done    = owner;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Command capture, latency counter and per-port response registers.
   // The response lands in the owner's registers on the edge that leaves
   // WAIT, so it is already valid during the done cycle and stays put until
   // that port completes another transaction. Writes return zero data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         owner      <= 1'b0;
         last_owner <= 1'b1;
         we_q       <= 1'b0;
         mem_addr   <= 32'h0;
         mem_data   <= 32'h0;
         mem_size   <= 2'b00;
         count      <= 4'd0;
         m0_rdata   <= 32'h0;
         m1_rdata   <= 32'h0;
         m0_err     <= 1'b0;
         m1_err     <= 1'b0;
      end else begin
         if (capture) begin
            owner      <= pick;
            last_owner <= pick;
            we_q       <= pick ? m1_we    : m0_we;
            mem_addr   <= pick ? m1_addr  : m0_addr;
            mem_data   <= pick ? m1_wdata : m0_wdata;
            mem_size   <= pick ? m1_size  : m0_size;
         end
         if (state == ISSUE) begin
            count <= 4'(MEM_LAT);
         end else if (state == WAIT) begin
            count <= count - 4'd1;
         end
         if (sample) begin
            if (owner) begin
               m1_rdata <= we_q ? 32'h0 : mem_out;
               m1_err   <= mem_error;
            end else begin
               m0_rdata <= we_q ? 32'h0 : mem_out;
               m0_err   <= mem_error;
            end
         end
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1: cycles from memory strobe to valid mem_out/mem_error; legal range 1..15.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-low reset: sampled on rising clk, asserted when 0.
REQ-004 m0_req, m1_req  in  1  access request from port 0 (CPU) / port 1 (loader/DMA).
REQ-005 m0_we, m1_we  in  1  1 = write, 0 = read.
REQ-006 m0_addr, m1_addr  in  32  byte address.
REQ-007 m0_wdata, m1_wdata  in  32  write data.
REQ-008 m0_size, m1_size  in  2  access size (00 byte, 01 half, 10 word).
REQ-009 m0_gnt, m1_gnt  out  1  one-cycle pulse: command captured.
REQ-010 m0_done, m1_done  out  1  one-cycle pulse: response valid.
REQ-011 m0_rdata, m1_rdata  out  32  read data, valid with done, held until that port's next done.
REQ-012 m0_err, m1_err  out  1  memory error, valid with done, held until that port's next done.
REQ-013 mem_rd, mem_we  out  1  memory read/write strobes.
REQ-014 mem_addr, mem_data, mem_size  out  32/32/2  memory command fields.
REQ-015 mem_out  in  32 and mem_error  in  1  memory response.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction in flight at a time.
REQ-017 IDLE: if any req sampled high, capture owner, we, addr, wdata, size; go ISSUE; otherwise stay IDLE.
REQ-018 Arbitration round-robin: single requester wins; both requesting -> winner is the port not equal to last_owner; last_owner updates on each capture.
REQ-019 ISSUE (one cycle): assert owner's gnt; mem_rd = !we, mem_we = we; load counter with MEM_LAT; go WAIT.
REQ-020 WAIT: decrement counter each cycle; when counter reaches 1, sample mem_out and mem_error at that clock edge; go RESP.
REQ-021 RESP (one cycle): assert owner's done; owner's rdata = sampled mem_out for reads, 32'h0 for writes; owner's err = sampled mem_error; go IDLE.
REQ-022 Latency: req high in IDLE at cycle t -> gnt at t+1, done at t+2+MEM_LAT (MEM_LAT=1: done at t+3); minimum spacing between grants MEM_LAT+3 cycles.
REQ-023 mem_rd/mem_we high only in ISSUE; mem_addr, mem_data, mem_size hold captured values from ISSUE through RESP and until next capture.
REQ-024 Requester holds req and command fields stable until gnt; req dropped before capture is ignored (no gnt, no done).
REQ-025 Req from either port during ISSUE/WAIT/RESP is not captured; it is arbitrated on return to IDLE.
REQ-026 gnt and done never asserted for both ports in the same cycle; non-owner rdata/err unchanged.
REQ-027 mem_error does not abort the FSM; the transaction completes normally with err=1.

Reset
REQ-028 rst=0 forces: state IDLE, last_owner=1 (port 0 wins first tie), counter 0, all gnt/done/mem_rd/mem_we 0, mem_addr/mem_data/mem_size 0, both rdata 0, both err 0.
REQ-029 Reset during ISSUE/WAIT/RESP aborts the transaction: no done is issued, strobes drop the cycle after the reset edge.

Verification
REQ-030 MEM_LAT=1; m0 read addr 0x100, mem_out=0xDEADBEEF at t+2 -> mem_rd=1 at t+1 only, m0_gnt t+1, m0_done t+3, m0_rdata=0xDEADBEEF, m0_err=0.
REQ-031 Both ports request continuously after reset -> grants alternate 0,1,0,1; spacing 4 cycles (MEM_LAT=1), never simultaneous.
REQ-032 m1 write addr 0x200 data 0x12345678 size 10 -> mem_we=1 one cycle, mem_addr=0x200, mem_data=0x12345678, mem_size=10; m1_done with m1_rdata=0.
REQ-033 MEM_LAT=3; read with mem_error=1 in sample cycle -> m0_done at t+5, m0_err=1, FSM back in IDLE at t+6.
REQ-034 rst=0 in WAIT -> no done pulse, all outputs reset next cycle; subsequent m1-only request granted normally.
REQ-035 m0 request while m1 transaction in WAIT -> m0 not granted until IDLE, then m0_gnt the cycle after IDLE.
